// File: rtl/my_mod_seq_ctrl_v1.sv
// my_mod_seq_ctrl_v1: square-wave modulation sequencer with frame-synchronous config apply and frame watchdog
module my_mod_seq_ctrl_v1 #(
  parameter int MIN_HP      = 4,
  parameter int TMO_PERIODS = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [31:0]        i_half_period,
  input  logic               i_cfg_wr,
  input  logic [31:0]        i_cfg_wait_cnt,
  input  logic [4:0]         i_cfg_avg_sel,
  input  logic signed [31:0] i_cfg_err_offset,
  input  logic               i_cfg_polarity,
  input  logic               i_frame_done,
  output logic               o_status,
  output logic               o_trig,
  output logic [31:0]        o_wait_cnt,
  output logic [31:0]        o_avg_sel,
  output logic signed [31:0] o_err_offset,
  output logic               o_polarity,
  output logic               o_cfg_pend,
  output logic               o_cfg_err,
  output logic               o_frame_tmo,
  output logic [1:0]         o_state
);
  localparam logic [1:0] IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2;
  logic [1:0]         state;
  logic [31:0]        cnt, hp, wd, hp_req, sh_wait;
  logic signed [31:0] sh_off;
  logic [4:0]         sh_avg, act_avg;
  logic               sh_pol, reject, apply, half_end, rise;
  logic [33:0]        need;
  always_comb begin
    hp_req   = (i_half_period < 32'(MIN_HP)) ? 32'(MIN_HP) : i_half_period;
    need     = {2'b0, i_cfg_wait_cnt} + (34'd1 << i_cfg_avg_sel[3:0]) + 34'd2;
    reject   = (i_cfg_avg_sel > 5'd15) || (need > {2'b0, hp_req});
    apply    = o_cfg_pend && (i_frame_done || state == IDLE);
    half_end = cnt == '0;
    rise     = state == LOW && half_end && i_en;
  end
  // hp is only re-latched entering HIGH, so the LOW half always mirrors it
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hp       <= '0;
      o_status <= 1'b0;
      o_trig   <= 1'b0;
    end else begin
      o_trig <= 1'b0;
      case (state)
        IDLE: if (i_en) begin
          state    <= HIGH;
          hp       <= hp_req;
          cnt      <= hp_req - 32'd1;
          o_status <= 1'b1;
        end
        HIGH: if (half_end) begin
          state    <= LOW;
          cnt      <= hp - 32'd1;
          o_status <= 1'b0;
          o_trig   <= 1'b1;
        end else cnt <= cnt - 32'd1;
        LOW: if (!half_end) cnt <= cnt - 32'd1;
        else if (i_en) begin
          state    <= HIGH;
          hp       <= hp_req;
          cnt      <= hp_req - 32'd1;
          o_status <= 1'b1;
          o_trig   <= 1'b1;
        end else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wd          <= '0;
      o_frame_tmo <= 1'b0;
    end else if (state == IDLE) begin
      wd <= '0;
      if (i_en) o_frame_tmo <= 1'b0;
    end else if (i_frame_done) wd <= '0;
    else if (rise) begin
      if (wd < 32'(TMO_PERIODS)) wd <= wd + 32'd1;
      if (wd >= 32'(TMO_PERIODS - 1)) o_frame_tmo <= 1'b1;
    end
  // apply uses the pre-edge shadow, so a same-cycle write stays pending
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      sh_wait      <= '0;
      sh_avg       <= '0;
      sh_off       <= '0;
      sh_pol       <= 1'b0;
      o_wait_cnt   <= '0;
      act_avg      <= '0;
      o_err_offset <= '0;
      o_polarity   <= 1'b0;
      o_cfg_pend   <= 1'b0;
      o_cfg_err    <= 1'b0;
    end else begin
      if (apply) begin
        o_wait_cnt   <= sh_wait;
        act_avg      <= sh_avg;
        o_err_offset <= sh_off;
        o_polarity   <= sh_pol;
        o_cfg_pend   <= 1'b0;
      end
      if (i_cfg_wr && reject) o_cfg_err <= 1'b1;
      else if (i_cfg_wr) begin
        sh_wait    <= i_cfg_wait_cnt;
        sh_avg     <= i_cfg_avg_sel;
        sh_off     <= i_cfg_err_offset;
        sh_pol     <= i_cfg_polarity;
        o_cfg_pend <= 1'b1;
        o_cfg_err  <= 1'b0;
      end
    end
  assign o_avg_sel = {27'b0, act_avg};
  assign o_state   = state;
endmodule

// File: tb/tb_my_mod_seq_ctrl_v1.sv
// tb_my_mod_seq_ctrl_v1: vector table for config writes plus scoreboarded modulation sequences
module tb_my_mod_seq_ctrl_v1;
  logic               i_clk = 1'b0, i_rst = 1'b1, i_en = 1'b0, i_cfg_wr = 1'b0;
  logic               i_cfg_polarity = 1'b0, i_frame_done = 1'b0;
  logic [31:0]        i_half_period = 32'd8, i_cfg_wait_cnt = 32'd0;
  logic [4:0]         i_cfg_avg_sel = 5'd0;
  logic signed [31:0] i_cfg_err_offset = 32'sd0;
  logic               o_status, o_trig, o_polarity, o_cfg_pend, o_cfg_err, o_frame_tmo;
  logic [31:0]        o_wait_cnt, o_avg_sel;
  logic signed [31:0] o_err_offset;
  logic [1:0]         o_state;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] hp, wt;
    logic [4:0] avg;
    logic signed [31:0] off;
    logic pol, err, pend;
    logic [31:0] e_wt, e_avg;
    logic signed [31:0] e_off;
    logic e_pol;
  } cfg_vec_t;
  typedef struct {
    logic st, tr;
    logic [1:0] fsm;
  } mod_exp_t;
  cfg_vec_t vecs[8];
  cfg_vec_t cfg_q[$];
  mod_exp_t mod_q[$];
  always #5 i_clk = ~i_clk;
  my_mod_seq_ctrl_v1 dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_half_period(i_half_period),
    .i_cfg_wr(i_cfg_wr), .i_cfg_wait_cnt(i_cfg_wait_cnt), .i_cfg_avg_sel(i_cfg_avg_sel),
    .i_cfg_err_offset(i_cfg_err_offset), .i_cfg_polarity(i_cfg_polarity),
    .i_frame_done(i_frame_done), .o_status(o_status), .o_trig(o_trig),
    .o_wait_cnt(o_wait_cnt), .o_avg_sel(o_avg_sel), .o_err_offset(o_err_offset),
    .o_polarity(o_polarity), .o_cfg_pend(o_cfg_pend), .o_cfg_err(o_cfg_err),
    .o_frame_tmo(o_frame_tmo), .o_state(o_state)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_status"}, 32'(o_status), 32'd0);
    chk({tag, "_trig"}, 32'(o_trig), 32'd0);
    chk({tag, "_wait"}, o_wait_cnt, 32'd0);
    chk({tag, "_avg"}, o_avg_sel, 32'd0);
    chk({tag, "_off"}, 32'(o_err_offset), 32'd0);
    chk({tag, "_pol"}, 32'(o_polarity), 32'd0);
    chk({tag, "_pend"}, 32'(o_cfg_pend), 32'd0);
    chk({tag, "_err"}, 32'(o_cfg_err), 32'd0);
    chk({tag, "_tmo"}, 32'(o_frame_tmo), 32'd0);
    chk({tag, "_state"}, 32'(o_state), 32'd0);
  endtask
  task automatic wait_state(input logic [1:0] s);
    int n;
    n = 0;
    while (o_state != s && n < 80) begin
      tick;
      n++;
    end
    chk("wait_state", 32'(o_state), 32'(s));
  endtask
  task automatic run_mod(input int drop_k);
    mod_exp_t m;
    int k;
    k = 0;
    while (mod_q.size() > 0) begin
      tick;
      k++;
      if (k == drop_k) i_en = 1'b0;
      m = mod_q.pop_front();
      chk("mod_status", 32'(o_status), 32'(m.st));
      chk("mod_trig", 32'(o_trig), 32'(m.tr));
      chk("mod_state", 32'(o_state), 32'(m.fsm));
    end
  endtask
  task automatic cfg_drive(input logic [31:0] wt, input logic [4:0] avg, input logic signed [31:0] off,
                           input logic pol, input logic fd);
    i_cfg_wait_cnt = wt;
    i_cfg_avg_sel = avg;
    i_cfg_err_offset = off;
    i_cfg_polarity = pol;
    i_cfg_wr = 1'b1;
    i_frame_done = fd;
    tick;
    i_cfg_wr = 1'b0;
    i_frame_done = 1'b0;
  endtask
  task automatic chk_cfg(input string tag, input logic [31:0] wt, input logic [31:0] avg,
                         input logic signed [31:0] off, input logic pol, input logic pend);
    chk({tag, "_wait"}, o_wait_cnt, wt);
    chk({tag, "_avg"}, o_avg_sel, avg);
    chk({tag, "_off"}, 32'(o_err_offset), 32'(off));
    chk({tag, "_pol"}, 32'(o_polarity), 32'(pol));
    chk({tag, "_pend"}, 32'(o_cfg_pend), 32'(pend));
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    cfg_vec_t e;
    int ph;
    vecs[0] = '{32'd16, 32'd3, 5'd2, -32'sd5, 1'b1, 1'b0, 1'b1, 32'd3, 32'd2, -32'sd5, 1'b1};
    vecs[1] = '{32'd8, 32'd4, 5'd1, 32'sd7, 1'b0, 1'b0, 1'b1, 32'd4, 32'd1, 32'sd7, 1'b0};
    vecs[2] = '{32'd8, 32'd4, 5'd2, 32'sd100, 1'b1, 1'b1, 1'b0, 32'd4, 32'd1, 32'sd7, 1'b0};
    vecs[3] = '{32'd8, 32'd0, 5'd16, 32'sd0, 1'b1, 1'b1, 1'b0, 32'd4, 32'd1, 32'sd7, 1'b0};
    vecs[4] = '{32'd1, 32'd1, 5'd0, -32'sd1, 1'b1, 1'b0, 1'b1, 32'd1, 32'd0, -32'sd1, 1'b1};
    vecs[5] = '{32'd1, 32'd2, 5'd0, 32'sd9, 1'b0, 1'b1, 1'b0, 32'd1, 32'd0, -32'sd1, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd15, 32'sd3, 1'b0, 1'b1, 1'b0, 32'd1, 32'd0, -32'sd1, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_0000, 5'd15, 32'sd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_0000, 32'd15, 32'sd0, 1'b0};
    #2;
    chk_zero("rst");
    tick;
    tick;
    i_rst = 1'b0;
    tick;
    chk_zero("post_rst");
    for (int i = 0; i < 8; i++) begin
      i_half_period = vecs[i].hp;
      cfg_q.push_back(vecs[i]);
      cfg_drive(vecs[i].wt, vecs[i].avg, vecs[i].off, vecs[i].pol, 1'b0);
      e = cfg_q.pop_front();
      chk("vec_pend", 32'(o_cfg_pend), 32'(e.pend));
      chk("vec_err", 32'(o_cfg_err), 32'(e.err));
      tick;
      chk_cfg("vec", e.e_wt, e.e_avg, e.e_off, e.e_pol, 1'b0);
    end
    i_half_period = 32'd8;
    i_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      ph = (k - 1) % 16;
      mod_q.push_back('{ph < 8, k > 1 && (ph == 0 || ph == 8), (ph < 8) ? 2'd1 : 2'd2});
    end
    run_mod(0);
    i_en = 1'b0;
    wait_state(2'd0);
    i_half_period = 32'd1;
    i_en = 1'b1;
    for (int k = 1; k <= 12; k++)
      mod_q.push_back('{k <= 4, k == 5, (k <= 4) ? 2'd1 : (k <= 8) ? 2'd2 : 2'd0});
    run_mod(2);
    i_half_period = 32'd16;
    i_en = 1'b1;
    tick;
    cfg_drive(32'd3, 5'd2, -32'sd5, 1'b1, 1'b0);
    chk_cfg("defer_hold", 32'hFFFF_0000, 32'd15, 32'sd0, 1'b0, 1'b1);
    repeat (3) tick;
    chk_cfg("defer_hold2", 32'hFFFF_0000, 32'd15, 32'sd0, 1'b0, 1'b1);
    i_frame_done = 1'b1;
    tick;
    i_frame_done = 1'b0;
    chk_cfg("defer_apply", 32'd3, 32'd2, -32'sd5, 1'b1, 1'b0);
    cfg_drive(32'd1, 5'd1, 32'sd11, 1'b0, 1'b0);
    cfg_drive(32'd2, 5'd0, 32'sd22, 1'b1, 1'b1);
    chk_cfg("simul_a", 32'd1, 32'd1, 32'sd11, 1'b0, 1'b1);
    repeat (2) tick;
    chk_cfg("simul_hold", 32'd1, 32'd1, 32'sd11, 1'b0, 1'b1);
    i_frame_done = 1'b1;
    tick;
    i_frame_done = 1'b0;
    chk_cfg("simul_b", 32'd2, 32'd0, 32'sd22, 1'b1, 1'b0);
    i_en = 1'b0;
    wait_state(2'd0);
    i_half_period = 32'd4;
    i_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (k == 1 || k == 25 || k == 32) chk("tmo_low", 32'(o_frame_tmo), 32'd0);
      if (k == 33 || k == 40) chk("tmo_high", 32'(o_frame_tmo), 32'd1);
      if (k == 33) chk("tmo_rise_status", 32'(o_status), 32'd1);
    end
    i_en = 1'b0;
    wait_state(2'd0);
    chk("tmo_idle_hold", 32'(o_frame_tmo), 32'd1);
    i_en = 1'b1;
    tick;
    chk("tmo_clear", 32'(o_frame_tmo), 32'd0);
    chk("restart_status", 32'(o_status), 32'd1);
    chk("restart_trig", 32'(o_trig), 32'd0);
    wait_state(2'd2);
    tick;
    #2 i_rst = 1'b1;
    #1 chk_zero("async_rst");
    #2 i_rst = 1'b0;
    tick;
    chk("post_rst_status", 32'(o_status), 32'd1);
    chk("post_rst_trig", 32'(o_trig), 32'd0);
    repeat (4) tick;
    chk("post_rst_fall_trig", 32'(o_trig), 32'd1);
    chk("post_rst_fall_status", 32'(o_status), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
